// File: rtl/ptw_dmem_adapter_if.sv
// PTW <-> data-cache request/response record types and a bundle of both
// directions for wiring an adapter to a cache model.

localparam int PTW_SIZE_VADDR = 39;
localparam int PTW_PADDR_W    = PTW_SIZE_VADDR + 1;

typedef logic [63:0] pte_t;

typedef struct packed {
    logic                   valid;
    logic [PTW_PADDR_W-1:0] addr;
    logic [4:0]             cmd;
    logic [3:0]             typ;
    logic                   kill;
    logic                   phys;
    logic [63:0]            data;
} ptw_dmem_comm_t;

typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic        has_data;
    logic        nack;
    logic        replay;
    logic        xcpt_ma_ld;
    logic        xcpt_pf_ld;
} dmem_ptw_resp_t;

typedef struct packed {
    logic           dmem_ready;
    dmem_ptw_resp_t resp;
} dmem_ptw_comm_t;

interface ptw_dmem_adapter_if;
    ptw_dmem_comm_t req;
    dmem_ptw_comm_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/ptw_dmem_adapter.sv
// Turns single PTE-read requests from the page-table walker into data-cache
// loads, retrying on nack/replay and reporting misalignment, faults and timeouts.

module ptw_dmem_adapter #(
    parameter int MAX_RETRIES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic [PTW_PADDR_W-1:0] req_addr_i,
    output logic                   req_ready_o,
    input  logic                   flush_i,
    output logic                   resp_valid_o,
    output logic                   resp_error_o,
    output pte_t                   resp_pte_o,
    input  dmem_ptw_comm_t         dmem_ptw_comm_i,
    output ptw_dmem_comm_t         ptw_dmem_comm_o
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int TMO_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [PTW_PADDR_W-1:0] r_addr;
    logic [PTW_PADDR_W-1:0] w_addr_next;
    logic [RETRY_W-1:0]     r_retry;
    logic [RETRY_W-1:0]     w_retry_next;
    logic [TMO_W-1:0]       r_tmo;
    logic [TMO_W-1:0]       w_tmo_next;
    logic [TMO_W-1:0]       w_tmo_inc;
    logic                   r_error;
    logic                   w_error_next;
    pte_t                   r_pte;
    pte_t                   w_pte_next;

    logic                   w_accept;
    logic                   w_retry_evt;
    logic                   w_xcpt_evt;
    logic                   w_data_evt;

    assign req_ready_o = (r_state == S_IDLE) & ~flush_i & ~rst_i;
    assign w_accept    = req_valid_i & req_ready_o;
    assign resp_pte_o  = r_pte;

    // Event priority in WAIT: retry request, then load exception, then data.
    assign w_retry_evt = dmem_ptw_comm_i.resp.nack | dmem_ptw_comm_i.resp.replay;
    assign w_xcpt_evt  = dmem_ptw_comm_i.resp.valid &
                         (dmem_ptw_comm_i.resp.xcpt_pf_ld | dmem_ptw_comm_i.resp.xcpt_ma_ld);
    assign w_data_evt  = dmem_ptw_comm_i.resp.valid & dmem_ptw_comm_i.resp.has_data;

    assign w_tmo_inc   = (r_tmo >= TMO_MAX) ? r_tmo : r_tmo + TMO_W'(1);

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_retry_next    = r_retry;
        w_tmo_next      = r_tmo;
        w_error_next    = r_error;
        w_pte_next      = r_pte;
        ptw_dmem_comm_o = '0;
        resp_valid_o    = 1'b0;
        resp_error_o    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_addr_next  = req_addr_i;
                    w_retry_next = '0;
                    w_tmo_next   = '0;
                    if (req_addr_i[2:0] != 3'b000) begin
                        w_error_next = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_error_next = 1'b0;
                        w_state_next = S_SEND;
                    end
                end
            end

            S_SEND: begin
                ptw_dmem_comm_o.valid = 1'b1;
                ptw_dmem_comm_o.addr  = r_addr;
                ptw_dmem_comm_o.cmd   = 5'b00000;
                ptw_dmem_comm_o.typ   = 4'b0011;
                ptw_dmem_comm_o.phys  = 1'b1;
                if (flush_i) begin
                    ptw_dmem_comm_o.kill = ~rst_i;
                    w_state_next         = S_IDLE;
                end else if (dmem_ptw_comm_i.dmem_ready) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (flush_i) begin
                    ptw_dmem_comm_o.kill = ~rst_i;
                    w_state_next         = S_IDLE;
                end else if (w_retry_evt) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_next = r_retry + RETRY_W'(1);
                        w_state_next = S_SEND;
                    end else begin
                        w_error_next = 1'b1;
                        w_state_next = S_RESP;
                    end
                end else if (w_xcpt_evt) begin
                    w_error_next = 1'b1;
                    w_state_next = S_RESP;
                end else if (w_data_evt) begin
                    w_pte_next   = dmem_ptw_comm_i.resp.data;
                    w_error_next = 1'b0;
                    w_state_next = S_RESP;
                end else if (w_tmo_inc >= TMO_MAX) begin
                    // The budget counts idle WAIT cycles over the whole request.
                    w_tmo_next   = w_tmo_inc;
                    w_error_next = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_tmo_next = w_tmo_inc;
                end
            end

            S_RESP: begin
                resp_valid_o = ~flush_i & ~rst_i;
                resp_error_o = r_error & ~flush_i & ~rst_i;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_error <= 1'b0;
            r_pte   <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_retry <= w_retry_next;
            r_tmo   <= w_tmo_next;
            r_error <= w_error_next;
            r_pte   <= w_pte_next;
        end
    end

endmodule

// File: tb/tb_ptw_dmem_adapter.sv
// Bench for ptw_dmem_adapter: directed table, randomized scripts against a
// transaction-level timing model, and hand sequences for flush and reset.

module tb_ptw_dmem_adapter;

    localparam int MAXR   = 4;
    localparam int TMO    = 8;
    localparam int BUDGET = 200;
    localparam int NV     = 8;

    localparam logic [2:0] K_NONE   = 3'd0;
    localparam logic [2:0] K_DATA   = 3'd1;
    localparam logic [2:0] K_NACK   = 3'd2;
    localparam logic [2:0] K_REPLAY = 3'd3;
    localparam logic [2:0] K_PF     = 3'd4;
    localparam logic [2:0] K_MA     = 3'd5;

    typedef struct packed {
        logic [39:0]      addr;
        logic [4:0][2:0]  kinds;
        logic [4:0][3:0]  dlys;
        logic [3:0]       stall;
        logic [63:0]      data;
        logic [7:0]       exp_issues;
        logic [7:0]       exp_cycle;
        logic             exp_err;
        logic [63:0]      exp_pte;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [39:0] req_addr_i;
    logic        req_ready_o;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_error_o;
    pte_t        resp_pte_o;

    ptw_dmem_adapter_if dif ();

    ptw_dmem_adapter #(
        .MAX_RETRIES    (MAXR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_ready_o     (req_ready_o),
        .flush_i         (flush_i),
        .resp_valid_o    (resp_valid_o),
        .resp_error_o    (resp_error_o),
        .resp_pte_o      (resp_pte_o),
        .dmem_ptw_comm_i (dif.resp),
        .ptw_dmem_comm_o (dif.req)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    logic [4:0][2:0] cur_kinds;
    logic [4:0][3:0] cur_dlys;
    int              cur_stall;
    logic [63:0]     cur_data;
    bit              cur_noise;

    int          got_issues;
    int          got_cycle;
    logic        got_err;
    logic [63:0] got_pte;
    logic [63:0] model_pte;

    vec_t tbl [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [39:0] a, input logic [14:0] k, input logic [19:0] d,
                                input logic [3:0] s, input logic [63:0] dat, input int ei,
                                input int ec, input logic ee, input logic [63:0] ep);
        vec_t v;
        v.addr       = a;
        v.kinds      = k;
        v.dlys       = d;
        v.stall      = s;
        v.data       = dat;
        v.exp_issues = 8'(ei);
        v.exp_cycle  = 8'(ec);
        v.exp_err    = ee;
        v.exp_pte    = ep;
        return v;
    endfunction

    task automatic drive_resp(input logic [2:0] kind, input logic [63:0] dat);
        dif.resp.resp = '0;
        case (kind)
            K_DATA: begin
                dif.resp.resp.valid = 1'b1; dif.resp.resp.has_data = 1'b1; dif.resp.resp.data = dat;
            end
            K_NACK: begin
                dif.resp.resp.valid = 1'b1; dif.resp.resp.has_data = 1'b1; dif.resp.resp.data = dat;
                dif.resp.resp.nack = 1'b1;
            end
            K_REPLAY: begin
                dif.resp.resp.replay = 1'b1; dif.resp.resp.data = dat;
            end
            K_PF: begin
                dif.resp.resp.valid = 1'b1; dif.resp.resp.has_data = 1'b1; dif.resp.resp.data = dat;
                dif.resp.resp.xcpt_pf_ld = 1'b1;
            end
            K_MA: begin
                dif.resp.resp.valid = 1'b1; dif.resp.resp.has_data = 1'b1; dif.resp.resp.data = dat;
                dif.resp.resp.xcpt_ma_ld = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Cache model: stalls each issue for cur_stall cycles, then answers issue k
    // cur_dlys[k] cycles after the handshake with cur_kinds[k].
    task automatic run_txn(input logic [39:0] addr);
        int  k;
        int  seen;
        int  pend_cyc;
        bit  pend;
        logic w_valid;
        k = 0; seen = 0; pend = 0; pend_cyc = 0;
        got_issues = 0; got_cycle = -1; got_err = 1'bx; got_pte = 'x;
        @(negedge clk_i);
        dif.resp    = '0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        #1;
        check("accept_ready", {63'd0, req_ready_o}, 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (c > 1) @(negedge clk_i);
            dif.resp = '0;
            w_valid  = dif.req.valid;
            dif.resp.dmem_ready = w_valid && (seen >= cur_stall);
            if (pend && c == pend_cyc) begin
                drive_resp(cur_kinds[k], cur_data);
                pend = 0;
                k++;
            end else if (w_valid && cur_noise) begin
                drive_resp(K_DATA, {$urandom, $urandom});
            end
            #1;
            if (dif.req.valid) begin
                check("req_addr", {24'd0, dif.req.addr}, {24'd0, addr});
                check("req_ctl", {55'd0, dif.req.cmd, dif.req.typ},
                      {55'd0, 5'b00000, 4'b0011});
                check("req_phys_kill_data", {dif.req.data[62:0], dif.req.phys} ^ {63'd0, dif.req.kill},
                      64'd1);
                seen++;
                if (dif.resp.dmem_ready) begin
                    got_issues++;
                    seen = 0;
                    if (k < 5 && cur_kinds[k] != K_NONE) begin
                        pend     = 1;
                        pend_cyc = c + int'(cur_dlys[k]);
                    end
                end
            end
            if (resp_valid_o) begin
                got_cycle = c;
                got_err   = resp_error_o;
                got_pte   = resp_pte_o;
                break;
            end
        end
        if (got_cycle < 0) begin
            check("resp_bound", 64'd0, 64'd1);
        end
        @(negedge clk_i);
        dif.resp = '0;
        #1;
        check("resp_pulse", {63'd0, resp_valid_o}, 64'd0);
        check("ready_after", {63'd0, req_ready_o}, 64'd1);
    endtask

    task automatic check_txn(input int e_iss, input int e_cyc, input logic e_err, input logic [63:0] e_pte);
        check("issues", 64'(got_issues), 64'(e_iss));
        check("resp_cycle", 64'(got_cycle), 64'(e_cyc));
        check("resp_error", {63'd0, got_err}, {63'd0, e_err});
        check("resp_pte", got_pte, e_pte);
    endtask

    // Transaction-level prediction from the request rules (cycle 0 = accept).
    task automatic model(input logic [39:0] addr, output int e_iss, output int e_cyc, output logic e_err);
        int t, h, retries, waited, d;
        e_iss = 0; e_cyc = 0; e_err = 1'b1;
        if (addr[2:0] != 3'b000) begin
            e_cyc = 1;
            return;
        end
        t = 1; retries = 0; waited = 0;
        for (int k = 0; k < 5; k++) begin
            h = t + cur_stall;
            e_iss++;
            d = int'(cur_dlys[k]);
            if (cur_kinds[k] == K_NONE || waited + d - 1 >= TMO) begin
                e_cyc = h + (TMO - waited) + 1;
                return;
            end
            waited += d - 1;
            e_cyc = h + d + 1;
            if (cur_kinds[k] == K_DATA) begin
                e_err = 1'b0;
                model_pte = cur_data;
                return;
            end
            if (cur_kinds[k] == K_PF || cur_kinds[k] == K_MA) return;
            if (retries >= MAXR) return;
            retries++;
            t = h + d + 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          e_iss, e_cyc;
        logic        e_err;
        logic [39:0] a;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
        dif.resp = '0;
        cur_noise = 0;

        tbl[0] = mk(40'h80001000, {K_NONE, K_NONE, K_NONE, K_NONE, K_DATA}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd3},
                    4'd0, 64'h200000CF, 1, 5, 1'b0, 64'h200000CF);
        tbl[1] = mk(40'h80001000, {K_NONE, K_NONE, K_DATA, K_NACK, K_NACK}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},
                    4'd0, 64'h1, 3, 7, 1'b0, 64'h1);
        tbl[2] = mk(40'h80001008, {K_NACK, K_NACK, K_NACK, K_NACK, K_NACK}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},
                    4'd0, 64'hDEAD, 5, 11, 1'b1, 64'h1);
        tbl[3] = mk(40'h80001004, {K_DATA, K_DATA, K_DATA, K_DATA, K_DATA}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},
                    4'd0, 64'hBEEF, 0, 1, 1'b1, 64'h1);
        tbl[4] = mk(40'h80002000, {K_NONE, K_NONE, K_NONE, K_NONE, K_NONE}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},
                    4'd0, 64'h0, 1, 10, 1'b1, 64'h1);
        tbl[5] = mk(40'h80003008, {K_NONE, K_NONE, K_NONE, K_PF, K_REPLAY}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd2},
                    4'd0, 64'h7, 2, 6, 1'b1, 64'h1);
        tbl[6] = mk(40'h80004010, {K_NONE, K_NONE, K_NONE, K_NONE, K_DATA}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},
                    4'd2, 64'hABCD000012345601, 1, 5, 1'b0, 64'hABCD000012345601);
        tbl[7] = mk(40'h80005018, {K_NONE, K_NONE, K_NONE, K_NONE, K_MA}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd2},
                    4'd1, 64'h5555, 1, 5, 1'b1, 64'hABCD000012345601);

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ready", {63'd0, req_ready_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rst_ready_after", {63'd0, req_ready_o}, 64'd1);
        check("rst_resp", {62'd0, resp_valid_o, resp_error_o}, 64'd0);
        check("rst_pte", resp_pte_o, 64'd0);
        check("rst_comm_valid", {63'd0, dif.req.valid}, 64'd0);
        check("rst_comm_addr", {24'd0, dif.req.addr}, 64'd0);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            cur_kinds = tbl[i].kinds;
            cur_dlys  = tbl[i].dlys;
            cur_stall = int'(tbl[i].stall);
            cur_data  = tbl[i].data;
            run_txn(tbl[i].addr);
            $display("vec %0d addr %h issues %0d cycle %0d err %0b pte %h",
                     i, tbl[i].addr, got_issues, got_cycle, got_err, got_pte);
            check_txn(int'(tbl[i].exp_issues), int'(tbl[i].exp_cycle), tbl[i].exp_err, tbl[i].exp_pte);
        end

        // Randomized scripts against the model
        model_pte = tbl[NV-1].exp_pte;
        for (int i = 0; i < 40; i++) begin
            a = {8'h80, $urandom} & 40'hFF_FFFF_FFF8;
            if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
            for (int k = 0; k < 5; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: cur_kinds[k] = K_DATA;
                    4, 5:       cur_kinds[k] = K_NACK;
                    6:          cur_kinds[k] = K_REPLAY;
                    7:          cur_kinds[k] = K_PF;
                    8:          cur_kinds[k] = K_MA;
                    default:    cur_kinds[k] = K_NONE;
                endcase
                cur_dlys[k] = 4'($urandom_range(1, 4));
            end
            cur_stall = $urandom_range(0, 2);
            cur_data  = {$urandom, $urandom};
            cur_noise = ($urandom_range(0, 1) == 1);
            model(a, e_iss, e_cyc, e_err);
            run_txn(a);
            $display("rnd %0d addr %h issues %0d cycle %0d err %0b pte %h",
                     i, a, got_issues, got_cycle, got_err, got_pte);
            check_txn(e_iss, e_cyc, e_err, model_pte);
        end
        cur_noise = 0;

        // Flush in WAIT, then late data is ignored
        @(negedge clk_i);
        dif.resp = '0; dif.resp.dmem_ready = 1'b1;
        req_valid_i = 1'b1; req_addr_i = 40'h80006000;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        check("s1_send", {63'd0, dif.req.valid}, 64'd1);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        check("s1_kill", {63'd0, dif.req.kill}, 64'd1);
        check("s1_no_resp", {63'd0, resp_valid_o}, 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        drive_resp(K_DATA, 64'h1234_5678_9ABC_DEF0);
        #1;
        check("s1_ready", {63'd0, req_ready_o}, 64'd1);
        check("s1_kill_drop", {63'd0, dif.req.kill}, 64'd0);
        @(negedge clk_i);
        dif.resp = '0;
        #1;
        check("s1_late_ignored", {63'd0, resp_valid_o}, 64'd0);
        $display("seq flush_wait done");
        run_txn(40'h80006001);
        check_txn(0, 1, 1'b1, model_pte);

        // Flush in SEND while the cache stalls
        @(negedge clk_i);
        dif.resp = '0;
        req_valid_i = 1'b1; req_addr_i = 40'h80007000;
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        check("s2_kill", {63'd0, dif.req.kill}, 64'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("s2_idle", {62'd0, dif.req.valid, req_ready_o}, 64'd1);
        $display("seq flush_send done");

        // Flush in IDLE blocks acceptance for that cycle
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 40'h80008002; flush_i = 1'b1;
        #1;
        check("s3_blocked", {63'd0, req_ready_o}, 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("s3_no_early_resp", {62'd0, resp_valid_o, req_ready_o}, 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        check("s3_resp", {62'd0, resp_valid_o, resp_error_o}, 64'd3);
        $display("seq flush_idle done");

        // Flush in RESP suppresses the response
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 40'h80009003;
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        check("s4_suppressed", {62'd0, resp_valid_o, resp_error_o}, 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("s4_ready", {62'd0, resp_valid_o, req_ready_o}, 64'd1);
        $display("seq flush_resp done");

        // Reset in WAIT discards the request without kill or response
        @(negedge clk_i);
        dif.resp = '0; dif.resp.dmem_ready = 1'b1;
        req_valid_i = 1'b1; req_addr_i = 40'h8000A000;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("s5_no_kill", {63'd0, dif.req.kill}, 64'd0);
        check("s5_rst_ready", {62'd0, resp_valid_o, req_ready_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_resp(K_DATA, 64'h0BAD_0BAD_0BAD_0BAD);
        #1;
        check("s5_ready", {62'd0, dif.req.valid, req_ready_o}, 64'd1);
        check("s5_pte_cleared", resp_pte_o, 64'd0);
        @(negedge clk_i);
        dif.resp = '0;
        #1;
        check("s5_no_resp", {63'd0, resp_valid_o}, 64'd0);
        $display("seq reset_wait done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ptw_dmem_adapter.md
PTW_DMEM_ADAPTER -- requirements
Module: ptw_dmem_adapter

Interface
REQ-001 SHALL have parameter MAX_RETRIES, default 4, max nack/replay retries per request before error.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before error.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid_i  input  1  PTW PTE-read request valid.
REQ-006 SHALL have port req_addr_i  input  SIZE_VADDR+1 (40)  physical PTE address.
REQ-007 SHALL have port req_ready_o  output  1  adapter accepts a request.
REQ-008 SHALL have port flush_i  input  1  abort in-flight read (csr_ptw_comm_t.flush).
REQ-009 SHALL have port resp_valid_o  output  1  one-cycle response pulse.
REQ-010 SHALL have port resp_error_o  output  1  response is an error; valid only with resp_valid_o.
REQ-011 SHALL have port resp_pte_o  output  pte_t (64)  returned PTE.
REQ-012 SHALL have port dmem_ptw_comm_i  input  dmem_ptw_comm_t  cache ready and response.
REQ-013 SHALL have port ptw_dmem_comm_o  output  ptw_dmem_comm_t  cache request.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT, RESP; one request outstanding.
REQ-015 req_ready_o SHALL be 1 only in IDLE; accept = req_valid_i & req_ready_o, latching req_addr_i and clearing retry and timeout counters.
REQ-016 On accept with req_addr_i[2:0] != 0: go to RESP with error=1, no dmem request issued.
REQ-017 On aligned accept: go to SEND.
REQ-018 In SEND: req.valid=1, addr=latched addr, cmd=5'b00000, typ=4'b0011, phys=1, kill=0, data=0; go to WAIT when dmem_ready=1, else hold SEND.
REQ-019 In all states other than SEND, req.valid SHALL be 0.
REQ-020 In WAIT, resp.valid & has_data & no xcpt: capture resp.data into resp_pte_o, go to RESP, error=0.
REQ-021 In WAIT, resp.nack or resp.replay (priority over data): if retry count < MAX_RETRIES, increment and go to SEND; else RESP with error=1.
REQ-022 In WAIT, resp.valid with xcpt_pf_ld or xcpt_ma_ld: RESP with error=1 (priority over data, below nack/replay).
REQ-023 Timeout counter SHALL increment each WAIT cycle without a qualifying event; reaching TIMEOUT_CYCLES: RESP with error=1.
REQ-024 In RESP: resp_valid_o=1 for exactly one cycle, then IDLE; resp_pte_o held until next captured data; resp_pte_o unchanged on error.
REQ-025 Latency, no stalls: accept cycle 0, dmem req.valid cycle 1, dmem response cycle N, resp_valid_o cycle N+1.
REQ-026 flush_i in SEND or WAIT: drive req.kill=1 for that cycle, go to IDLE, no response.
REQ-027 flush_i in RESP: suppress resp_valid_o, go to IDLE.
REQ-028 flush_i in IDLE: block accept that cycle (req_ready_o=0).
REQ-029 dmem responses arriving in IDLE, SEND or RESP SHALL be ignored (stale after flush).
REQ-030 Counters SHALL saturate, never wrap.

Reset
REQ-031 rst_i=1 at a clock edge: FSM to IDLE, counters 0, resp_pte_o=0, resp_valid_o=0, resp_error_o=0, all ptw_dmem_comm_o fields 0, from the next cycle.
REQ-032 Reset mid-operation SHALL discard the in-flight request without kill or response.
REQ-033 req_ready_o SHALL be 0 while rst_i=1 and 1 the first cycle after deassertion.

Verification
REQ-034 Aligned read 0x80001000, dmem_ready=1, data 0x200000CF after 3 cycles -> one req.valid pulse, resp_valid_o=1, error=0, pte 0x200000CF at cycle 5.
REQ-035 Two nacks then data 0x1 -> three req.valid issues, resp error=0, pte 0x1.
REQ-036 Five consecutive nacks, MAX_RETRIES=4 -> five issues, then resp error=1.
REQ-037 Addr 0x80001004 -> no req.valid, resp error=1 at cycle 1.
REQ-038 flush_i in WAIT, then late data -> kill=1 one cycle, no resp_valid_o, req_ready_o=1 next cycle.
REQ-039 No dmem response, TIMEOUT_CYCLES=8 -> resp error=1 after 8 WAIT cycles.
